// File: rtl/ps2_dir_decoder.sv
// PS/2 receive path: synchronise and filter, deserialise 11-bit frames, then turn
// arrow make/break sequences into one-cycle direction pulses. Define PS2_WASD_EN to also map W/S/A/D.
module ps2_dir_decoder #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk_crystal,
    input  logic       rst_global_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err,
    output logic       kb_up,
    output logic       kb_down,
    output logic       kb_left,
    output logic       kb_right
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic          clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
    logic          filt_q, filt_prev_q, fall_q;
    logic [FW-1:0] filt_cnt_q;

    // Synchronisers idle high so a reset never manufactures a falling edge.
    always_ff @(posedge clk_crystal or negedge rst_global_n) begin
        if (!rst_global_n) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            dat_meta_q  <= 1'b1;
            dat_sync_q  <= 1'b1;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            fall_q      <= 1'b0;
            filt_cnt_q  <= '0;
        end else begin
            clk_meta_q  <= ps2_clk;
            clk_sync_q  <= clk_meta_q;
            dat_meta_q  <= ps2_data;
            dat_sync_q  <= dat_meta_q;
            filt_prev_q <= filt_q;
            fall_q      <= filt_prev_q & ~filt_q;
            if (clk_sync_q == filt_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_q     <= clk_sync_q;
                filt_cnt_q <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + 1'b1;
            end
        end
    end

    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          good_d, bad_d;
    logic [7:0]    scan_code_q;
    logic          scan_valid_q, frame_err_q;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        good_d    = 1'b0;
        bad_d     = 1'b0;
        tmo_d     = (state_q == S_IDLE || fall_q) ? '0 : tmo_q + 1'b1;
        if (fall_q) begin
            case (state_q)
                S_IDLE: begin
                    if (!dat_sync_q) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end
                end
                S_DATA: begin
                    shift_d   = {dat_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_d   = dat_sync_q;
                    state_d = S_STOP;
                end
                default: begin
                    state_d = S_IDLE;
                    if (dat_sync_q && ^{shift_q, par_q}) good_d = 1'b1;
                    else                                 bad_d  = 1'b1;
                end
            endcase
        end else if (state_q != S_IDLE && tmo_q == TW'(TIMEOUT_CYC)) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk_crystal or negedge rst_global_n) begin
        if (!rst_global_n) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            tmo_q        <= '0;
            scan_code_q  <= '0;
            scan_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            tmo_q        <= tmo_d;
            scan_valid_q <= good_d;
            frame_err_q  <= bad_d;
            if (good_d) scan_code_q <= shift_q;
        end
    end

    logic       ext_q, ext_d, brk_q, brk_d;
    logic [3:0] held_q, held_d, pulse_d, kb_q;
    logic       hit;
    logic [1:0] idx;

    always_comb begin
        hit = 1'b0;
        idx = 2'd0;
        if (ext_q) begin
            case (scan_code_q)
                8'h75:   begin hit = 1'b1; idx = 2'd0; end
                8'h72:   begin hit = 1'b1; idx = 2'd1; end
                8'h6B:   begin hit = 1'b1; idx = 2'd2; end
                8'h74:   begin hit = 1'b1; idx = 2'd3; end
                default: hit = 1'b0;
            endcase
        end
`ifdef PS2_WASD_EN
        else begin
            case (scan_code_q)
                8'h1D:   begin hit = 1'b1; idx = 2'd0; end
                8'h1B:   begin hit = 1'b1; idx = 2'd1; end
                8'h1C:   begin hit = 1'b1; idx = 2'd2; end
                8'h23:   begin hit = 1'b1; idx = 2'd3; end
                default: hit = 1'b0;
            endcase
        end
`endif
    end

    // Bit order of held/pulse: up, down, left, right.
    always_comb begin
        ext_d   = ext_q;
        brk_d   = brk_q;
        held_d  = held_q;
        pulse_d = '0;
        if (frame_err_q) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (scan_valid_q) begin
            if (scan_code_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (scan_code_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                if (hit) begin
                    if (brk_q) begin
                        held_d[idx] = 1'b0;
                    end else if (!held_q[idx]) begin
                        held_d[idx]  = 1'b1;
                        pulse_d[idx] = 1'b1;
                    end
                end
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_crystal or negedge rst_global_n) begin
        if (!rst_global_n) begin
            ext_q  <= 1'b0;
            brk_q  <= 1'b0;
            held_q <= '0;
            kb_q   <= '0;
        end else begin
            ext_q  <= ext_d;
            brk_q  <= brk_d;
            held_q <= held_d;
            kb_q   <= pulse_d;
        end
    end

    assign scan_code  = scan_code_q;
    assign scan_valid = scan_valid_q;
    assign frame_err  = frame_err_q;
    assign kb_up      = kb_q[0];
    assign kb_down    = kb_q[1];
    assign kb_left    = kb_q[2];
    assign kb_right   = kb_q[3];
endmodule

// File: tb/tb_ps2_dir_decoder.sv
// Bench for ps2_dir_decoder: table of byte sequences with hand-derived deltas, corner
// sequences (glitch, timeout, mid-frame reset) and random bytes against a byte-level key model.
module tb_ps2_dir_decoder;
    localparam int TMO  = 1000;
    localparam int HALF = 16;
`ifdef PS2_WASD_EN
    localparam int WASD_UP = 1;
`else
    localparam int WASD_UP = 0;
`endif

    logic       clk = 1'b0, rst_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic [7:0] scan_code;
    logic       scan_valid, frame_err, kb_up, kb_down, kb_left, kb_right;

    ps2_dir_decoder #(.FILTER_LEN(8), .TIMEOUT_CYC(TMO)) dut (
        .clk_crystal(clk), .rst_global_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .scan_code(scan_code), .scan_valid(scan_valid), .frame_err(frame_err),
        .kb_up(kb_up), .kb_down(kb_down), .kb_left(kb_left), .kb_right(kb_right)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, txn = 0;
    int valid_cnt = 0, err_cnt = 0;
    int kb_cnt[4] = '{0, 0, 0, 0};
    logic prev_valid = 1'b0, prev_err = 1'b0;

    // Monitor: counts pulses, checks kb follows scan_valid by one cycle and pulses are single-cycle.
    always @(negedge clk) begin
        logic [3:0] kb;
        kb = {kb_right, kb_left, kb_down, kb_up};
        if (scan_valid) valid_cnt++;
        if (frame_err) err_cnt++;
        for (int i = 0; i < 4; i++) if (kb[i]) kb_cnt[i]++;
        if (kb != 4'b0) begin
            checks++;
            if ($countones(kb) != 1 || !prev_valid) begin
                errors++;
                $display("FAIL kb_timing: kb=%b prev_scan_valid=%0b, need one-hot kb one cycle after scan_valid", kb, prev_valid);
            end
        end
        if (scan_valid || frame_err) begin
            checks++;
            if (prev_valid || prev_err || (scan_valid && frame_err)) begin
                errors++;
                $display("FAIL pulse_width: valid=%0b err=%0b prev_valid=%0b prev_err=%0b, need isolated single pulse",
                         scan_valid, frame_err, prev_valid, prev_err);
            end
        end
        prev_valid = scan_valid;
        prev_err   = frame_err;
    end

    // Byte-level reference model of the key decoder.
    logic       m_ext = 0, m_brk = 0;
    logic [3:0] m_held = '0;
    int         exp_kb[4] = '{0, 0, 0, 0};
    int         exp_valid = 0, exp_err = 0;
    logic [7:0] exp_code = 8'h00;

    function automatic int dir_of(input logic [7:0] b, input logic ext);
        if (ext) begin
            if (b == 8'h75) return 0;
            if (b == 8'h72) return 1;
            if (b == 8'h6B) return 2;
            if (b == 8'h74) return 3;
        end else if (WASD_UP == 1) begin
            if (b == 8'h1D) return 0;
            if (b == 8'h1B) return 1;
            if (b == 8'h1C) return 2;
            if (b == 8'h23) return 3;
        end
        return -1;
    endfunction

    task automatic model_byte(input logic [7:0] b, input bit bad);
        int d;
        if (bad) begin
            exp_err++;
            m_ext = 0;
            m_brk = 0;
        end else begin
            exp_valid++;
            exp_code = b;
            if (b == 8'hE0) m_ext = 1;
            else if (b == 8'hF0) m_brk = 1;
            else begin
                d = dir_of(b, m_ext);
                if (d >= 0) begin
                    if (m_brk) m_held[d] = 0;
                    else if (!m_held[d]) begin
                        m_held[d] = 1;
                        exp_kb[d]++;
                    end
                end
                m_ext = 0;
                m_brk = 0;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v, input bit glitch);
        ps2_data = v;
        if (glitch) begin
            wait_cyc(5);
            ps2_clk = 1'b0;
            wait_cyc(3);
            ps2_clk = 1'b1;
        end
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit glitch);
        logic [10:0] fr;
        fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) send_bit(fr[i], glitch && (i == 3));
        wait_cyc(8);
        model_byte(b, bad_par | bad_stop);
        txn++;
        $display("txn %0d: byte %02h bad_par=%0b bad_stop=%0b glitch=%0b -> code=%02h valids=%0d errs=%0d kb u/d/l/r=%0d/%0d/%0d/%0d",
                 txn, b, bad_par, bad_stop, glitch, scan_code, valid_cnt, err_cnt,
                 kb_cnt[0], kb_cnt[1], kb_cnt[2], kb_cnt[3]);
        chk("scan_valid_count", valid_cnt, exp_valid);
        chk("frame_err_count", err_cnt, exp_err);
        chk("scan_code", int'(scan_code), int'(exp_code));
        for (int i = 0; i < 4; i++) chk($sformatf("kb_count[%0d]", i), kb_cnt[i], exp_kb[i]);
    endtask

    typedef struct {
        logic [7:0] b [8];
        int         n;
        logic [7:0] bad_par;
        logic [7:0] bad_stop;
        int         d_up, d_down, d_left, d_right, d_err;
        logic [7:0] code;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #800000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_up, s_dn, s_lf, s_rt, s_err;
        bit rst_bad;
        logic [7:0] rb;
        logic [7:0] pool[12];

        vecs[0] = '{b:'{8'hE0,8'h75,0,0,0,0,0,0}, n:2, bad_par:8'h00, bad_stop:8'h00,
                    d_up:1, d_down:0, d_left:0, d_right:0, d_err:0, code:8'h75};
        vecs[1] = '{b:'{8'hE0,8'h74,8'hE0,8'h74,8'hE0,8'h74,0,0}, n:6, bad_par:8'h00, bad_stop:8'h00,
                    d_up:0, d_down:0, d_left:0, d_right:1, d_err:0, code:8'h74};
        vecs[2] = '{b:'{8'hE0,8'hF0,8'h74,8'hE0,8'h74,0,0,0}, n:5, bad_par:8'h00, bad_stop:8'h00,
                    d_up:0, d_down:0, d_left:0, d_right:1, d_err:0, code:8'h74};
        vecs[3] = '{b:'{8'h6B,0,0,0,0,0,0,0}, n:1, bad_par:8'h01, bad_stop:8'h00,
                    d_up:0, d_down:0, d_left:0, d_right:0, d_err:1, code:8'h74};
        vecs[4] = '{b:'{8'hE0,8'h6B,0,0,0,0,0,0}, n:2, bad_par:8'h00, bad_stop:8'h00,
                    d_up:0, d_down:0, d_left:1, d_right:0, d_err:0, code:8'h6B};
        vecs[5] = '{b:'{8'hE0,8'h72,0,0,0,0,0,0}, n:2, bad_par:8'h00, bad_stop:8'h01,
                    d_up:0, d_down:0, d_left:0, d_right:0, d_err:1, code:8'h72};
        vecs[6] = '{b:'{8'hE0,8'h72,0,0,0,0,0,0}, n:2, bad_par:8'h00, bad_stop:8'h00,
                    d_up:0, d_down:1, d_left:0, d_right:0, d_err:0, code:8'h72};
        vecs[7] = '{b:'{8'hE0,8'hF0,8'h75,8'h1D,0,0,0,0}, n:4, bad_par:8'h00, bad_stop:8'h00,
                    d_up:WASD_UP, d_down:0, d_left:0, d_right:0, d_err:0, code:8'h1D};
        vecs[8] = '{b:'{8'hF0,8'h1D,8'hE0,8'h75,0,0,0,0}, n:4, bad_par:8'h00, bad_stop:8'h00,
                    d_up:1, d_down:0, d_left:0, d_right:0, d_err:0, code:8'h75};

        // Reset state.
        wait_cyc(10);
        @(negedge clk);
        chk("reset_scan_code", int'(scan_code), 0);
        chk("reset_flags", int'({scan_valid, frame_err, kb_up, kb_down, kb_left, kb_right}), 0);
        wait_cyc(1);
        rst_n = 1'b1;
        wait_cyc(20);

        for (int v = 0; v < 9; v++) begin
            s_up = kb_cnt[0]; s_dn = kb_cnt[1]; s_lf = kb_cnt[2]; s_rt = kb_cnt[3]; s_err = err_cnt;
            for (int k = 0; k < vecs[v].n; k++)
                send_byte(vecs[v].b[k], vecs[v].bad_par[k], vecs[v].bad_stop[k], 1'b0);
            chk($sformatf("vec%0d_up", v), kb_cnt[0] - s_up, vecs[v].d_up);
            chk($sformatf("vec%0d_down", v), kb_cnt[1] - s_dn, vecs[v].d_down);
            chk($sformatf("vec%0d_left", v), kb_cnt[2] - s_lf, vecs[v].d_left);
            chk($sformatf("vec%0d_right", v), kb_cnt[3] - s_rt, vecs[v].d_right);
            chk($sformatf("vec%0d_err", v), err_cnt - s_err, vecs[v].d_err);
            chk($sformatf("vec%0d_code", v), int'(scan_code), int'(vecs[v].code));
        end

        // Glitches on ps2_clk while idle and inside frames must not shift bits.
        send_byte(8'hE0, 0, 0, 0); send_byte(8'hF0, 0, 0, 0); send_byte(8'h74, 0, 0, 0);
        s_rt = kb_cnt[3];
        ps2_clk = 1'b0; wait_cyc(3); ps2_clk = 1'b1; wait_cyc(HALF);
        send_byte(8'hE0, 0, 0, 1); send_byte(8'h74, 0, 0, 1);
        chk("glitch_right", kb_cnt[3] - s_rt, 1);

        // Partial frame abandoned by timeout, then a clean E0 72.
        send_byte(8'hE0, 0, 0, 0); send_byte(8'hF0, 0, 0, 0); send_byte(8'h72, 0, 0, 0);
        s_dn = kb_cnt[1]; s_err = err_cnt;
        for (int i = 0; i < 5; i++) send_bit(i == 0 ? 1'b0 : 1'b1, 1'b0);
        wait_cyc(TMO + 20);
        send_byte(8'hE0, 0, 0, 0); send_byte(8'h72, 0, 0, 0);
        chk("timeout_down", kb_cnt[1] - s_dn, 1);
        chk("timeout_no_err", err_cnt - s_err, 0);

        // Reset in the middle of a frame clears the partial frame and key state.
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b0);
        rst_n = 1'b0;
        rst_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (scan_code != 8'h00 || scan_valid || frame_err || kb_up || kb_down || kb_left || kb_right) rst_bad = 1;
        end
        chk("outputs_zero_in_reset", int'(rst_bad), 0);
        wait_cyc(1);
        rst_n = 1'b1;
        m_ext = 0; m_brk = 0; m_held = '0; exp_code = 8'h00;
        wait_cyc(20);
        s_up = kb_cnt[0];
        send_byte(8'hE0, 0, 0, 0); send_byte(8'h75, 0, 0, 0);
        chk("post_reset_up", kb_cnt[0] - s_up, 1);
        send_byte(8'hE0, 0, 0, 0); send_byte(8'hF0, 0, 0, 0); send_byte(8'h75, 0, 0, 0);
        s_up = kb_cnt[0];
        send_byte(8'h1D, 0, 0, 0);
        chk("wasd_w_up", kb_cnt[0] - s_up, WASD_UP);

        // Random byte stream against the model.
        pool = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'hE0, 8'hF0};
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 5) == 0) rb = 8'($urandom);
            else rb = pool[$urandom_range(0, 11)];
            send_byte(rb, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_dir_decoder.md
# ps2_dir_decoder

Receives the raw PS/2 keyboard stream, deserialises and checks device-to-host frames, and turns arrow-key make/break sequences into single-cycle direction pulses. Sits directly upstream of the snake direction logic: its `kb_up/kb_down/kb_left/kb_right` outputs feed the `dir_next` selection in the top level. It is receive-only and never drives the PS/2 lines.

## Interface
- `FILTER_LEN`, 8: consecutive identical `ps2_clk` samples required before the filtered clock changes.
- `TIMEOUT_CYC`, 100000: idle cycles (1 ms at 100 MHz) after which a partial frame is discarded.
- `clk_crystal`  input  1  100 MHz system clock.
- `rst_global_n`  input  1  asynchronous, active-low reset.
- `ps2_clk`  input  1  raw PS/2 clock, asynchronous.
- `ps2_data`  input  1  raw PS/2 data, asynchronous.
- `scan_code`  output  8  last good received byte; held until the next good byte.
- `scan_valid`  output  1  one-cycle pulse when `scan_code` updates.
- `frame_err`  output  1  one-cycle pulse on a parity or stop-bit error.
- `kb_up`, `kb_down`, `kb_left`, `kb_right`  output  1 each  one-cycle make pulse.

## Operation
- Both inputs pass through 2-FF synchronisers. `ps2_clk` is then filtered: the filtered clock takes a new level only after `FILTER_LEN` consecutive equal synchronised samples. A falling edge is filtered high→low.
- Frame FSM, advancing on each falling edge:
  - IDLE: sampled data 0 (start bit) → DATA, bit count 0. Sampled 1 is ignored; stay in IDLE.
  - DATA: shift the bit in LSB first. After the 8th bit → PARITY.
  - PARITY: store the bit, → STOP.
  - STOP: return to IDLE. The frame is good if the stop bit is 1 and the 9 data+parity bits have odd parity. Good frame → `scan_code` loads and `scan_valid` pulses. Bad frame → `frame_err` pulses and the byte is dropped.
- Timeout: in any state other than IDLE, a counter runs from 0 and resets on each falling edge. When it reaches `TIMEOUT_CYC`, the FSM returns to IDLE silently, without `frame_err`.
- Key decoder, acting on each good byte:
  - `E0` sets `ext`.
  - `F0` sets `brk`.
  - Any other byte: if `ext`=1 and the code is `75`/`72`/`6B`/`74` (up/down/left/right), then with `brk`=1 the matching `held` bit is cleared. With `brk`=0 and the `held` bit clear, the matching `kb_*` pulses and `held` is set. Finally `ext` and `brk` are cleared.
  - `held` suppresses typematic repeats: no second pulse until that key's break code.
- A bad frame clears `ext` and `brk`; `held` bits are kept.
- At most one `kb_*` pulse per byte, so `kb_*` outputs are mutually exclusive by construction.

## Timing
- Reset, asynchronous and active-low: FSM IDLE, counters 0. `scan_code`=8'h00; `scan_valid`, `frame_err` and all `kb_*` = 0. `ext`, `brk` and `held` = 0. The filtered clock resets to 1.
- Edge latency: raw `ps2_clk` fall → filtered falling edge detected after 2 + `FILTER_LEN` + 1 cycles.
- Let the stop bit's falling edge be detected in cycle N:
  - `scan_valid` or `frame_err` is high in cycle N+1 only.
  - `kb_*` is high in cycle N+2 only.
- Reset asserted mid-frame discards the partial frame and all prefix state. After deassertion the first falling edge is treated as a potential start bit.
- A falling edge in the same cycle as timeout expiry is honoured: the counter resets and the FSM does not go to IDLE.

## Configuration
- `PS2_WASD_EN` defined: non-extended make/break of `1D`/`1B`/`1C`/`23` (W/S/A/D) also drive up/down/left/right. They share the same `held` bits as the arrows, so the first make of either source pulses and either break clears.
- Not defined: only E0-prefixed arrow codes produce pulses. W/S/A/D bytes still appear on `scan_code` and `scan_valid`.

## Test plan
- Send frames `E0`,`75` with correct odd parity → `scan_valid` twice; `scan_code`=8'h75 after the second; exactly one `kb_up` pulse at N+2; no other `kb_*`.
- Send `E0 74` three times (typematic), then `E0 F0 74`, then `E0 74` → exactly two `kb_right` pulses in total.
- Send `6B` with the parity bit inverted → `frame_err` 1 cycle; no `scan_valid`; `scan_code` unchanged. Then a good `E0 6B` → one `kb_left` pulse.
- Send start bit plus 4 data bits, then hold `ps2_clk` high for 100001 cycles, then a full good `E0 72` → no `frame_err`; one `kb_down`.
- Inject 3-cycle glitches low on `ps2_clk` during idle and mid-frame, with `FILTER_LEN`=8 → no bit shifts; the frame decodes correctly.
- Assert `rst_global_n`=0 after 5 bits of a frame, release, send `E0 75` → all outputs 0 during reset; one `kb_up`. With `PS2_WASD_EN`, `1D` → one `kb_up`; without it, no pulse.
